// File: rtl/tensor_core_mma_engine.sv
// Sequential NxN signed matrix multiply(-accumulate) engine: one result element per clock,
// optional saturation, sticky overflow, start/busy/done handshake.
module tensor_core_mma_engine #(
   parameter int N      = 4,
   parameter int DATA_W = 8
) (
   input  logic                               clock_in,
   input  logic                               reset_in,
   input  logic                               tensor_core_register_file_write_enable,
   input  logic                               should_start_tensor_core,
   input  logic                               accumulate_mode,
   input  logic                               saturate_enable,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]    tensor_core_input1,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]    tensor_core_input2,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]    tensor_core_input3,
   output logic [N-1:0][N-1:0][DATA_W-1:0]    tensor_core_output,
   output logic                               is_busy,
   output logic                               is_done_with_calculation,
   output logic                               overflow
);
   localparam int SUM_W  = 2*DATA_W + $clog2(N) + 1;
   localparam int PROD_W = 2*DATA_W;
   localparam int RC_W   = $clog2(N);
   localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                            state_q, state_d;
   logic [RC_W-1:0]                   row_q, row_d, col_q, col_d;
   logic                              ovf_q, ovf_d;
   logic                              acc_q, acc_d;
   logic                              sat_q, sat_d;
   logic [N-1:0][N-1:0][DATA_W-1:0]   result_q;

   logic signed [PROD_W-1:0]          a_ext [N];
   logic signed [PROD_W-1:0]          b_ext [N];
   logic signed [PROD_W-1:0]          prod  [N];
   logic signed [SUM_W-1:0]           sum;
   logic [DATA_W-1:0]                 elem_val;
   logic                              elem_ovf;
   logic                              write_elem;

   // One dot-product term per k: A[row][k] * B[k][col] at full precision.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_prod
         assign a_ext[gi] = {{DATA_W{tensor_core_input1[row_q][gi][DATA_W-1]}}, tensor_core_input1[row_q][gi]};
         assign b_ext[gi] = {{DATA_W{tensor_core_input2[gi][col_q][DATA_W-1]}}, tensor_core_input2[gi][col_q]};
         assign prod[gi]  = a_ext[gi] * b_ext[gi];
      end
   endgenerate

   always_comb begin
      sum = '0;
      for (int k = 0; k < N; k++) begin
         sum = sum + {{(SUM_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
      end
      if (acc_q) begin
         sum = sum + {{(SUM_W-DATA_W){tensor_core_input3[row_q][col_q][DATA_W-1]}},
                      tensor_core_input3[row_q][col_q]};
      end
   end

   always_comb begin
      elem_ovf = (sum > MAX_V) || (sum < MIN_V);
      elem_val = sum[DATA_W-1:0];
      if (sat_q && (sum > MAX_V)) begin
         elem_val = MAX_V[DATA_W-1:0];
      end else if (sat_q && (sum < MIN_V)) begin
         elem_val = MIN_V[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      ovf_d      = ovf_q;
      acc_d      = acc_q;
      sat_d      = sat_q;
      write_elem = 1'b0;
      // A register-file write aborts everything; written elements and overflow stay as they are.
      if (tensor_core_register_file_write_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (should_start_tensor_core) begin
                  state_d = S_BUSY;
                  row_d   = '0;
                  col_d   = '0;
                  ovf_d   = 1'b0;
                  acc_d   = accumulate_mode;
                  sat_d   = saturate_enable;
               end
            end
            S_BUSY: begin
               write_elem = 1'b1;
               if (elem_ovf) ovf_d = 1'b1;
               if (col_q == RC_W'(N-1)) begin
                  col_d = '0;
                  if (row_q == RC_W'(N-1)) begin
                     col_d   = col_q;
                     state_d = S_DONE;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         ovf_q    <= 1'b0;
         acc_q    <= 1'b0;
         sat_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ovf_q   <= ovf_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         if (write_elem) begin
            result_q[row_q][col_q] <= elem_val;
         end
      end
   end

   assign tensor_core_output       = result_q;
   assign is_busy                  = (state_q == S_BUSY);
   assign is_done_with_calculation = (state_q == S_DONE);
   assign overflow                 = ovf_q;

endmodule

// File: tb/tb_tensor_core_mma_engine.sv
// Bench for tensor_core_mma_engine (N=4, DATA_W=8): directed scenarios plus random traffic,
// compared every cycle against a matrix-level reference model.
module tb_tensor_core_mma_engine;
   logic clk = 1'b0, rst = 1'b0, we = 1'b0, start = 1'b0, acc = 1'b0, sat = 1'b0;
   logic [3:0][3:0][7:0] a_p = '0, b_p = '0, c_p = '0;
   logic [3:0][3:0][7:0] r_p;
   logic busy, done, ovf;

   int checks = 0;
   int failures = 0;

   tensor_core_mma_engine #(.N(4), .DATA_W(8)) dut (
      .clock_in                               (clk),
      .reset_in                               (rst),
      .tensor_core_register_file_write_enable (we),
      .should_start_tensor_core               (start),
      .accumulate_mode                        (acc),
      .saturate_enable                        (sat),
      .tensor_core_input1                     (a_p),
      .tensor_core_input2                     (b_p),
      .tensor_core_input3                     (c_p),
      .tensor_core_output                     (r_p),
      .is_busy                                (busy),
      .is_done_with_calculation               (done),
      .overflow                               (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int el(input logic [3:0][3:0][7:0] m, input int r, input int c);
      logic signed [7:0] t;
      t = m[r][c];
      return int'(t);
   endfunction

   // Reference arithmetic: plain integer dot product, then clamp or wrap to 8 bits.
   function automatic void expect_elem(input int r, input int c, input bit acc_m, input bit sat_m,
                                       output int v, output bit ex);
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += el(a_p, r, k) * el(b_p, k, c);
      if (acc_m) s += el(c_p, r, c);
      ex = (s > 127) || (s < -128);
      if (sat_m) v = (s > 127) ? 127 : ((s < -128) ? -128 : s);
      else begin
         v = ((s % 256) + 256) % 256;
         if (v > 127) v -= 256;
      end
   endfunction

   // Model: 0 idle, 1 busy, 2 done; whole result precomputed at start, revealed one element per clock.
   int m_r[4][4] = '{default: 0};
   int m_exp[4][4];
   bit m_exo[4][4];
   int m_state = 0, m_idx = 0, n_ops = 0;
   bit m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      int r, c;
      if (rst) begin
         m_state = 0; m_idx = 0; m_ovf = 1'b0;
         for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_r[i][j] = 0;
      end else if (we) begin
         m_state = 0;
      end else if (m_state != 1 && start) begin
         m_state = 1; m_idx = 0; m_ovf = 1'b0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) expect_elem(i, j, acc, sat, m_exp[i][j], m_exo[i][j]);
      end else if (m_state == 1) begin
         r = m_idx / 4; c = m_idx % 4;
         m_r[r][c] = m_exp[r][c];
         if (m_exo[r][c]) m_ovf = 1'b1;
         m_idx++;
         if (m_idx == 16) begin
            m_state = 2;
            n_ops++;
            $display("op %0d complete overflow=%0b", n_ops, m_ovf);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", busy, (m_state == 1));
         chk("done", done, (m_state == 2));
         chk("overflow", ovf, m_ovf);
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) chk($sformatf("R[%0d][%0d]", i, j), el(r_p, i, j), m_r[i][j]);
      end
   end

   task automatic run_op(output int n);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic set_identity();
      a_p = '0;
      for (int i = 0; i < 4; i++) a_p[i][i] = 8'd1;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b_p[i][j] = 8'(4*i + j + 1);
   endtask

   task automatic chk_all(input string name, input int v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) chk($sformatf("%s[%0d][%0d]", name, i, j), el(r_p, i, j), v);
   endtask

   function automatic logic [7:0] rnd_el(input bit big);
      return big ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15) - 8);
   endfunction

   initial begin
      int n;
      bit big;
      #1 rst = 1'b1;
      #12 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovf", ovf, 0);
      chk_all("reset_R", 0);

      set_identity(); set_ramp(); acc = 1'b0; sat = 1'b1;
      run_op(n);
      $display("identity x ramp: latency=%0d", n);
      chk("latency_mult", n, 16);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) chk($sformatf("ident_R[%0d][%0d]", i, j), el(r_p, i, j), 4*i + j + 1);
      chk("ident_ovf", ovf, 0);

      set_identity(); b_p = {16{8'd2}}; c_p = {16{8'd3}}; acc = 1'b1;
      run_op(n);
      $display("identity x 2 + 3: latency=%0d", n);
      chk("latency_acc", n, 16);
      chk_all("acc_R", 5);

      a_p = {16{8'd127}}; b_p = {16{8'd127}}; acc = 1'b0; sat = 1'b1;
      run_op(n);
      $display("127x127 saturating");
      chk_all("satpos_R", 127);
      chk("satpos_ovf", ovf, 1);

      sat = 1'b0;
      run_op(n);
      $display("127x127 wrapping");
      chk_all("wrap_R", 4);
      chk("wrap_ovf", ovf, 1);

      a_p = {16{8'h80}}; sat = 1'b1;
      run_op(n);
      $display("-128x127 saturating");
      chk_all("satneg_R", -128);
      chk("satneg_ovf", ovf, 1);

      set_identity();
      run_op(n);
      $display("identity x 127 after overflow");
      chk("ovf_cleared", ovf, 0);
      chk_all("ident127_R", 127);

      a_p = {16{8'd127}}; b_p = {16{8'd127}}; sat = 1'b0;
      run_op(n);
      set_identity(); set_ramp(); sat = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) begin @(posedge clk); @(negedge clk); end
      we = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      we = 1'b0; start = 1'b0;
      $display("abort on 6th busy clock");
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            chk($sformatf("abort_R[%0d][%0d]", i, j), el(r_p, i, j),
                (i == 0 || (i == 1 && j == 0)) ? 4*i + j + 1 : 4);
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("abort_stays_idle", busy, 0);

      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      $display("async reset mid-operation");
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_ovf", ovf, 0);
      chk_all("midrst_R", 0);
      @(negedge clk);
      #2 rst = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         we    = ($urandom_range(0, 99) < 4);
         start = ($urandom_range(0, 99) < 25);
         if (we || m_state != 1) begin
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  a_p[i][j] = rnd_el(big);
                  b_p[i][j] = rnd_el(big);
                  c_p[i][j] = rnd_el(1'b1);
               end
            acc = 1'($urandom_range(0, 1));
            sat = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      we = 1'b0; start = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
